// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared widths, zero-register index and priority-state encoding.
package reg_write_arbiter_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;
    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_e;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: two writeback request channels plus the registered register-bank write port.
interface reg_write_arbiter_if #(parameter int n = 64);
    import reg_write_arbiter_pkg::*;
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_address;
    logic [n-1:0]          req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_address;
    logic [n-1:0]          req1_data;
    logic                  req1_ready;
    logic                  write;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [n-1:0]          write_data;
    logic                  last_grant;
    modport master (
        output req0_valid, req0_address, req0_data, req1_valid, req1_address, req1_data,
        input  req0_ready, req1_ready, write, write_address, write_data, last_grant
    );
    modport slave (
        input  req0_valid, req0_address, req0_data, req1_valid, req1_address, req1_data,
        output req0_ready, req1_ready, write, write_address, write_data, last_grant
    );
endinterface

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant logic; the loser of the last grant is favored next.
module rr_arbiter2
    import reg_write_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic stall,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);
    pri_e state_q, state_d;
    logic open;
    always_comb begin
        open = !stall && !reset;
        grant0 = open && valid0 && (!valid1 || state_q == PRI0);
        grant1 = open && valid1 && (!valid0 || state_q == PRI1);
        state_d = grant0 ? PRI1 : grant1 ? PRI0 : state_q;
    end
    always_ff @(posedge clock) begin
        if (reset) state_q <= PRI0;
        else state_q <= state_d;
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: arbitrates ALU and load writebacks onto one registered register-bank write port.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int n = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    reg_write_arbiter_if.slave bus
);
    logic grant0, grant1, grant;
    logic [ADDR_WIDTH-1:0] sel_address, write_address_q, write_address_d;
    logic [n-1:0] sel_data, write_data_q, write_data_d;
    logic write_q, write_d, last_grant_q, last_grant_d;
    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .stall  (stall),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );
    always_comb begin
        grant = grant0 || grant1;
        sel_address = grant1 ? bus.req1_address : bus.req0_address;
        sel_data = grant1 ? bus.req1_data : bus.req0_data;
        // Zero-register writes are consumed but never reach the bank.
        write_d = grant && sel_address != ZERO_REG;
        write_address_d = grant ? sel_address : write_address_q;
        write_data_d = grant ? sel_data : write_data_q;
        last_grant_d = grant1 ? 1'b1 : grant0 ? 1'b0 : last_grant_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q <= 1'b0;
            write_address_q <= '0;
            write_data_q <= '0;
            last_grant_q <= 1'b1;
        end else begin
            write_q <= write_d;
            write_address_q <= write_address_d;
            write_data_q <= write_data_d;
            last_grant_q <= last_grant_d;
        end
    end
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.write = write_q;
    assign bus.write_address = write_address_q;
    assign bus.write_data = write_data_q;
    assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and random stimulus checked against a rule-level arbitration model.
module tb_reg_write_arbiter;
    logic clock = 1'b0;
    logic reset, stall;
    int compared = 0, mismatched = 0;
    int fav;
    logic exp_w, exp_l, addr_ok;
    logic [4:0] exp_a;
    logic [63:0] exp_d;
    reg_write_arbiter_if #(.n(64)) bus ();
    reg_write_arbiter #(.n(64)) dut (.clock(clock), .reset(reset), .stall(stall), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input logic r, input logic s,
                        input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [63:0] d1);
        int g;
        logic [4:0] ga;
        reset = r; stall = s;
        bus.req0_valid = v0; bus.req0_address = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_address = a1; bus.req1_data = d1;
        g = (r || s) ? -1 : (v0 && v1) ? fav : v0 ? 0 : v1 ? 1 : -1;
        #1;
        chk("req0_ready", {63'd0, bus.req0_ready}, {63'd0, g == 0});
        chk("req1_ready", {63'd0, bus.req1_ready}, {63'd0, g == 1});
        @(posedge clock);
        #1;
        if (r) begin
            exp_w = 0; exp_a = 0; exp_d = 0; exp_l = 1; fav = 0; addr_ok = 1;
        end else if (g >= 0) begin
            ga = (g == 1) ? a1 : a0;
            exp_w = ga != 5'd31;
            exp_a = ga;
            exp_d = (g == 1) ? d1 : d0;
            exp_l = (g == 1);
            fav = 1 - g;
            addr_ok = exp_w;
        end else begin
            exp_w = 0;
        end
        chk("write", {63'd0, bus.write}, {63'd0, exp_w});
        chk("last_grant", {63'd0, bus.last_grant}, {63'd0, exp_l});
        if (addr_ok) begin
            chk("write_address", {59'd0, bus.write_address}, {59'd0, exp_a});
            chk("write_data", bus.write_data, exp_d);
        end
        @(negedge clock);
    endtask
    initial begin
        fav = 0; exp_w = 0; exp_l = 1; exp_a = 0; exp_d = 0; addr_ok = 1;
        reset = 1; stall = 0;
        bus.req0_valid = 0; bus.req0_address = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_address = 0; bus.req1_data = 0;
        @(negedge clock);
        step(1, 0, 1, 5'd7, 64'h77, 1, 5'd8, 64'h88);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5'd3, 64'hA5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_address", {59'd0, bus.write_address}, 64'd3);
        chk("hold_data", bus.write_data, 64'hA5);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 5'd1, 64'h11, 1, 5'd2, 64'h22);
        step(0, 0, 0, 0, 0, 1, 5'd31, 64'hFF);
        step(0, 0, 1, 5'd4, 64'h44, 0, 0, 0);
        step(0, 0, 1, 5'd5, 64'h1, 1, 5'd5, 64'h2);
        chk("same_addr_first", bus.write_data, 64'h2);
        step(0, 0, 1, 5'd5, 64'h1, 0, 0, 0);
        chk("same_addr_final", bus.write_data, 64'h1);
        step(0, 0, 1, 5'd9, 64'h9, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 5'd10, 64'hA, 1, 5'd11, 64'hB);
        step(0, 0, 1, 5'd10, 64'hA, 1, 5'd11, 64'hB);
        chk("after_stall_winner", {63'd0, bus.last_grant}, 64'd1);
        step(0, 0, 1, 5'd12, 64'hC, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                 {$urandom, $urandom},
                 $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                 {$urandom, $urandom});
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
